rtc_prescaler: RTL

RTC_PRESCALER -- requirements
Module: rtc_prescaler

---
 rtl/rtc_prescaler_reg_pkg.sv | 50 +++++
 rtl/rtc_prescaler.sv | 131 +++++++++++++
 2 files changed

// File: rtl/rtc_prescaler_reg_pkg.sv
// Register map, bit positions and default OBI bus types for the RTC prescaler.
// Shared by the prescaler RTL and anything that drives its bus.
package rtc_prescaler_reg_pkg;

    localparam int unsigned IntAddrWidth = 4;
    localparam int unsigned IdWidth      = 4;

    localparam logic [IntAddrWidth-1:0] RTC_PRESCALER_CTRL_OFFSET   = 4'h0;
    localparam logic [IntAddrWidth-1:0] RTC_PRESCALER_DIV_OFFSET    = 4'h4;
    localparam logic [IntAddrWidth-1:0] RTC_PRESCALER_STATUS_OFFSET = 4'h8;

    localparam int unsigned RTC_PRESCALER_CTRL_EN_BIT    = 0;
    localparam int unsigned RTC_PRESCALER_CTRL_CLR_BIT   = 1;
    localparam int unsigned RTC_PRESCALER_STATUS_RTC_BIT = 0;
    localparam int unsigned RTC_PRESCALER_STATUS_EN_BIT  = 1;

    localparam logic [31:0] RTC_PRESCALER_ERR_RDATA = 32'hBADCAB1E;

    typedef struct packed {
        logic               req;
        logic               we;
        logic [3:0]         be;
        logic [31:0]        addr;
        logic [31:0]        wdata;
        logic [IdWidth-1:0] aid;
    } rtc_obi_req_t;

    typedef struct packed {
        logic               gnt;
        logic               rvalid;
        logic [31:0]        rdata;
        logic               err;
        logic [IdWidth-1:0] rid;
    } rtc_obi_rsp_t;

    // Byte-lane merge of a write into an existing 32-bit register.
    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Programmable square-wave RTC generator with an OBI register interface.
// Half-period of rtc_o is DIV_active+1 clocks; DIV_active reloads only at toggles or while disabled.
module rtc_prescaler
    import rtc_prescaler_reg_pkg::*;
#(
    parameter type         obi_req_t = rtc_obi_req_t,
    parameter type         obi_rsp_t = rtc_obi_rsp_t,
    parameter int unsigned ResetDiv  = 32'd1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    output logic     rtc_o,
    output logic     tick_o
);

    logic               r_en;
    logic [31:0]        r_div;
    logic [31:0]        r_div_act;
    logic [31:0]        r_cnt;
    logic               r_rtc;
    logic               r_tick;
    logic               r_rvalid;
    logic               r_err;
    logic [31:0]        r_rdata;
    logic [IdWidth-1:0] r_rid;

    logic [IntAddrWidth-1:0] w_off;
    logic                    w_wr;
    logic                    w_wr_ctrl;
    logic                    w_wr_div;
    logic                    w_clr;
    logic                    w_wrap;
    logic                    w_toggle;
    logic                    w_rd_err;
    logic                    w_wr_err;
    logic [31:0]             w_rd_data;
    logic                    w_unused;

    assign w_off     = {obi_req_i.addr[IntAddrWidth-1:2], 2'b00};
    assign w_wr      = obi_req_i.req & obi_req_i.we;
    assign w_wr_ctrl = w_wr & (w_off == RTC_PRESCALER_CTRL_OFFSET) & obi_req_i.be[0];
    assign w_wr_div  = w_wr & (w_off == RTC_PRESCALER_DIV_OFFSET);
    assign w_clr     = w_wr_ctrl & obi_req_i.wdata[RTC_PRESCALER_CTRL_CLR_BIT];
    assign w_wrap    = (r_cnt == r_div_act);
    // A clear in the same cycle wins over the toggle, so no reload happens then either.
    assign w_toggle  = r_en & w_wrap & ~w_clr;
    assign w_wr_err  = (w_off != RTC_PRESCALER_CTRL_OFFSET) & (w_off != RTC_PRESCALER_DIV_OFFSET);
    assign w_unused  = ^{obi_req_i.addr[31:IntAddrWidth], obi_req_i.addr[1:0]};

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        case (w_off)
            RTC_PRESCALER_CTRL_OFFSET: begin
                w_rd_data[RTC_PRESCALER_CTRL_EN_BIT] = r_en;
            end
            RTC_PRESCALER_DIV_OFFSET: begin
                w_rd_data = r_div;
            end
            RTC_PRESCALER_STATUS_OFFSET: begin
                w_rd_data[RTC_PRESCALER_STATUS_RTC_BIT] = r_rtc;
                w_rd_data[RTC_PRESCALER_STATUS_EN_BIT]  = r_en;
            end
            default: begin
                w_rd_data = RTC_PRESCALER_ERR_RDATA;
                w_rd_err  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_en      <= 1'b0;
            r_div     <= 32'(ResetDiv);
            r_div_act <= 32'(ResetDiv);
            r_cnt     <= '0;
            r_rtc     <= 1'b0;
            r_tick    <= 1'b0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_rid     <= '0;
        end else begin
            r_rvalid <= obi_req_i.req;
            if (obi_req_i.req) begin
                r_rid   <= obi_req_i.aid;
                r_err   <= obi_req_i.we ? w_wr_err : w_rd_err;
                r_rdata <= obi_req_i.we ? 32'd0 : w_rd_data;
            end

            if (w_wr_ctrl) begin
                r_en <= obi_req_i.wdata[RTC_PRESCALER_CTRL_EN_BIT];
            end
            if (w_wr_div) begin
                r_div <= apply_be(r_div, obi_req_i.wdata, obi_req_i.be);
            end

            if (w_clr) begin
                r_cnt <= '0;
                r_rtc <= 1'b0;
            end else if (r_en) begin
                if (w_wrap) begin
                    r_cnt <= '0;
                    r_rtc <= ~r_rtc;
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end

            if (!r_en || w_toggle) begin
                r_div_act <= r_div;
            end
            r_tick <= w_toggle & ~r_rtc;
        end
    end

    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = 1'b1;
        obi_rsp_o.rvalid = r_rvalid;
        obi_rsp_o.rdata  = r_rdata;
        obi_rsp_o.err    = r_err;
        obi_rsp_o.rid    = r_rid;
    end

    assign rtc_o  = r_rtc;
    assign tick_o = r_tick;

endmodule
